// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, state encoding,
// ALU operation codes, instruction classes and the registered control word.
package cpu_ctrl_pkg;

  localparam int OPW  = 5;
  localparam int ALUW = 4;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_T0   = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4   = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_HALT = 4'd7
  } state_t;

  typedef enum logic [ALUW-1:0] {
    ALU_NONE = 4'd0,  ALU_ADD = 4'd1,  ALU_SUB = 4'd2,  ALU_AND = 4'd3,
    ALU_OR   = 4'd4,  ALU_SHR = 4'd5,  ALU_SHRA = 4'd6, ALU_SHL = 4'd7,
    ALU_ROR  = 4'd8,  ALU_ROL = 4'd9,  ALU_MUL = 4'd10, ALU_DIV = 4'd11,
    ALU_NEG  = 4'd12, ALU_NOT = 4'd13
  } alu_op_t;

  typedef enum logic [2:0] {
    CL_ALU3 = 3'd0, CL_MULDIV = 3'd1, CL_UNARY = 3'd2, CL_MFHI = 3'd3,
    CL_MFLO = 3'd4, CL_NOP = 3'd5, CL_HALT = 3'd6
  } instr_class_t;

  typedef struct packed {
    logic pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out;
    logic pc_in, mar_in, ir_in, z_in, y_in, hi_in, lo_in;
    logic inc_pc, read, gra, grb, grc, r_in, r_out, illegal, run;
    alu_op_t alu_op;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer (master) and the single-bus datapath (slave).
interface control_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic [31:0]     IR;
  logic            mem_ready;
  logic            PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
  logic            PCin, MARin, MDRin, IRin, Zin, Yin, HIin, LOin;
  logic            IncPC, Read, Gra, Grb, Grc, Rin, Rout;
  logic [ALUW-1:0] alu_op;
  logic            Run, illegal_op;

  modport master (
    input  IR, mem_ready,
    output PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
    output PCin, MARin, MDRin, IRin, Zin, Yin, HIin, LOin,
    output IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, Run, illegal_op
  );

  modport slave (
    output IR, mem_ready,
    input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
    input  PCin, MARin, MDRin, IRin, Zin, Yin, HIin, LOin,
    input  IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, Run, illegal_op
  );

endinterface

// File: rtl/control_sequencer_decoder.sv
// Combinational opcode decode: instruction class, ALU operation and illegal flag.
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output instr_class_t   iclass,
  output alu_op_t        alu_op,
  output logic           illegal
);

  // Map opcode to execute class and ALU function; unknown opcodes run as nop plus illegal
  always_comb begin
    iclass  = CL_NOP;
    alu_op  = ALU_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_ADD:  begin iclass = CL_ALU3;   alu_op = ALU_ADD;  end
      OP_SUB:  begin iclass = CL_ALU3;   alu_op = ALU_SUB;  end
      OP_AND:  begin iclass = CL_ALU3;   alu_op = ALU_AND;  end
      OP_OR:   begin iclass = CL_ALU3;   alu_op = ALU_OR;   end
      OP_SHR:  begin iclass = CL_ALU3;   alu_op = ALU_SHR;  end
      OP_SHRA: begin iclass = CL_ALU3;   alu_op = ALU_SHRA; end
      OP_SHL:  begin iclass = CL_ALU3;   alu_op = ALU_SHL;  end
      OP_ROR:  begin iclass = CL_ALU3;   alu_op = ALU_ROR;  end
      OP_ROL:  begin iclass = CL_ALU3;   alu_op = ALU_ROL;  end
      OP_MUL:  begin iclass = CL_MULDIV; alu_op = ALU_MUL;  end
      OP_DIV:  begin iclass = CL_MULDIV; alu_op = ALU_DIV;  end
      OP_NEG:  begin iclass = CL_UNARY;  alu_op = ALU_NEG;  end
      OP_NOT:  begin iclass = CL_UNARY;  alu_op = ALU_NOT;  end
      OP_MFHI: iclass = CL_MFHI;
      OP_MFLO: iclass = CL_MFLO;
      OP_NOP:  iclass = CL_NOP;
      OP_HALT: iclass = CL_HALT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, class-dependent execute T3-T6, HALT.
// The control word is registered alongside the state; Clear forces strobes low immediately.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic Clock,
  input  logic Clear,
  control_sequencer_if.master bus
);

  state_t         state, ns;
  ctrl_t          ctrl_r;
  logic [OPW-1:0] opcode_r, op_sel;
  instr_class_t   cls;
  alu_op_t        dec_alu;
  logic           dec_ill;

  // The opcode enters the decoder straight from IR on the T2->T3 edge, then from the latch
  assign op_sel = (state == S_T2) ? bus.IR[31:32-OPW] : opcode_r;

  instr_decoder u_dec (
    .opcode  (op_sel),
    .iclass  (cls),
    .alu_op  (dec_alu),
    .illegal (dec_ill)
  );

  function automatic ctrl_t ctrl_of(state_t s, instr_class_t c, alu_op_t a, logic ill);
    ctrl_t o;
    o     = '0;
    o.run = 1'b1;
    case (s)
      S_T0: begin o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.z_in = 1'b1; end
      S_T1: begin o.zlow_out = 1'b1; o.pc_in = 1'b1; o.read = 1'b1; end
      S_T2: begin o.mdr_out = 1'b1; o.ir_in = 1'b1; end
      S_T3: case (c)
        CL_ALU3:   begin o.grb = 1'b1; o.r_out = 1'b1; o.y_in = 1'b1; end
        CL_MULDIV: begin o.gra = 1'b1; o.r_out = 1'b1; o.y_in = 1'b1; end
        CL_UNARY:  begin o.grb = 1'b1; o.r_out = 1'b1; o.z_in = 1'b1; o.alu_op = a; end
        CL_MFHI:   begin o.hi_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
        CL_MFLO:   begin o.lo_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
        default:   o.illegal = ill;
      endcase
      S_T4: case (c)
        CL_ALU3:   begin o.grc = 1'b1; o.r_out = 1'b1; o.z_in = 1'b1; o.alu_op = a; end
        CL_MULDIV: begin o.grb = 1'b1; o.r_out = 1'b1; o.z_in = 1'b1; o.alu_op = a; end
        CL_UNARY:  begin o.zlow_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
        default:   o.run = 1'b1;
      endcase
      S_T5: case (c)
        CL_ALU3:   begin o.zlow_out = 1'b1; o.gra = 1'b1; o.r_in = 1'b1; end
        CL_MULDIV: begin o.zlow_out = 1'b1; o.lo_in = 1'b1; end
        default:   o.run = 1'b1;
      endcase
      S_T6:    begin o.zhigh_out = 1'b1; o.hi_in = 1'b1; end
      S_HALT:  o.run = 1'b0;
      default: o.run = 1'b1;
    endcase
    return o;
  endfunction

  // Next-state selection from the current step and the instruction class
  always_comb begin
    ns = S_T0;
    case (state)
      S_T0: ns = S_T1;
      S_T1: ns = bus.mem_ready ? S_T2 : S_T1;
      S_T2: ns = S_T3;
      S_T3: case (cls)
        CL_ALU3, CL_MULDIV, CL_UNARY: ns = S_T4;
        CL_HALT:                      ns = S_HALT;
        default:                      ns = S_T0;
      endcase
      S_T4:    ns = (cls == CL_ALU3 || cls == CL_MULDIV) ? S_T5 : S_T0;
      S_T5:    ns = (cls == CL_MULDIV) ? S_T6 : S_T0;
      S_T6:    ns = S_T0;
      S_HALT:  ns = S_HALT;
      default: ns = S_T0;
    endcase
  end

  // State, opcode latch and the control word for the state being entered
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state    <= S_T0;
      opcode_r <= '0;
      ctrl_r   <= ctrl_of(S_T0, CL_NOP, ALU_NONE, 1'b0);
    end else begin
      state    <= ns;
      opcode_r <= (state == S_T2) ? bus.IR[31:32-OPW] : opcode_r;
      ctrl_r   <= ctrl_of(ns, cls, dec_alu, dec_ill);
    end
  end

  assign bus.PCout      = ctrl_r.pc_out    & ~Clear;
  assign bus.MDRout     = ctrl_r.mdr_out   & ~Clear;
  assign bus.Zhighout   = ctrl_r.zhigh_out & ~Clear;
  assign bus.Zlowout    = ctrl_r.zlow_out  & ~Clear;
  assign bus.HIout      = ctrl_r.hi_out    & ~Clear;
  assign bus.LOout      = ctrl_r.lo_out    & ~Clear;
  assign bus.PCin       = ctrl_r.pc_in     & ~Clear;
  assign bus.MARin      = ctrl_r.mar_in    & ~Clear;
  assign bus.MDRin      = (state == S_T1) & bus.mem_ready & ~Clear;
  assign bus.IRin       = ctrl_r.ir_in     & ~Clear;
  assign bus.Zin        = ctrl_r.z_in      & ~Clear;
  assign bus.Yin        = ctrl_r.y_in      & ~Clear;
  assign bus.HIin       = ctrl_r.hi_in     & ~Clear;
  assign bus.LOin       = ctrl_r.lo_in     & ~Clear;
  assign bus.IncPC      = ctrl_r.inc_pc    & ~Clear;
  assign bus.Read       = ctrl_r.read      & ~Clear;
  assign bus.Gra        = ctrl_r.gra       & ~Clear;
  assign bus.Grb        = ctrl_r.grb       & ~Clear;
  assign bus.Grc        = ctrl_r.grc       & ~Clear;
  assign bus.Rin        = ctrl_r.r_in      & ~Clear;
  assign bus.Rout       = ctrl_r.r_out     & ~Clear;
  assign bus.illegal_op = ctrl_r.illegal   & ~Clear;
  assign bus.Run        = ctrl_r.run       |  Clear;
  assign bus.alu_op     = Clear ? ALU_NONE : ctrl_r.alu_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a micro-step list model of each instruction.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  logic Clock = 1'b0;
  logic Clear = 1'b1;
  control_sequencer_if bus();

  control_sequencer dut (.Clock(Clock), .Clear(Clear), .bus(bus.master));

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [21:0] PCOUT = 22'd1 << 21, MDROUT = 22'd1 << 20, ZHIGHOUT = 22'd1 << 19;
  localparam logic [21:0] ZLOWOUT = 22'd1 << 18, HIOUT = 22'd1 << 17, LOOUT = 22'd1 << 16;
  localparam logic [21:0] PCIN = 22'd1 << 15, MARIN = 22'd1 << 14, MDRIN = 22'd1 << 13;
  localparam logic [21:0] IRIN = 22'd1 << 12, ZIN = 22'd1 << 11, YIN = 22'd1 << 10;
  localparam logic [21:0] HIIN = 22'd1 << 9, LOIN = 22'd1 << 8, INCPC = 22'd1 << 7;
  localparam logic [21:0] READ = 22'd1 << 6, GRA = 22'd1 << 5, GRB = 22'd1 << 4;
  localparam logic [21:0] GRC = 22'd1 << 3, RIN = 22'd1 << 2, ROUT = 22'd1 << 1, ILL = 22'd1;
  localparam logic [21:0] M_T0 = PCOUT | MARIN | INCPC | ZIN;

  logic [21:0] dut_mask;
  assign dut_mask = {bus.PCout, bus.MDRout, bus.Zhighout, bus.Zlowout, bus.HIout, bus.LOout,
                     bus.PCin, bus.MARin, bus.MDRin, bus.IRin, bus.Zin, bus.Yin, bus.HIin,
                     bus.LOin, bus.IncPC, bus.Read, bus.Gra, bus.Grb, bus.Grc, bus.Rin,
                     bus.Rout, bus.illegal_op};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: each instruction is a list of micro-steps ----
  // kind: 1 three-register ALU, 2 mul/div, 3 neg/not, 4 mfhi, 5 mflo, 6 nop, 7 halt, 0 unsupported
  function automatic int kind(logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: return 1;
      5'b01111, 5'b10000: return 2;
      5'b10001, 5'b10010: return 3;
      5'b11000: return 4;
      5'b11001: return 5;
      5'b11010: return 6;
      5'b11011: return 7;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(logic [4:0] op);
    case (op)
      5'b00011: return ALU_ADD;  5'b00100: return ALU_SUB;  5'b00101: return ALU_AND;
      5'b00110: return ALU_OR;   5'b00111: return ALU_SHR;  5'b01000: return ALU_SHRA;
      5'b01001: return ALU_SHL;  5'b01010: return ALU_ROR;  5'b01011: return ALU_ROL;
      5'b01111: return ALU_MUL;  5'b10000: return ALU_DIV;  5'b10001: return ALU_NEG;
      5'b10010: return ALU_NOT;
      default:  return ALU_NONE;
    endcase
  endfunction

  function automatic int instr_len(logic [4:0] op);
    case (kind(op))
      1: return 6;
      2: return 7;
      3: return 5;
      default: return 4;
    endcase
  endfunction

  function automatic logic [21:0] step_mask(logic [4:0] op, int k);
    logic [21:0] steps [7];
    steps[0] = M_T0;
    steps[1] = ZLOWOUT | PCIN | READ;
    steps[2] = MDROUT | IRIN;
    steps[3] = 22'd0; steps[4] = 22'd0; steps[5] = 22'd0; steps[6] = 22'd0;
    case (kind(op))
      1: begin steps[3] = GRB | ROUT | YIN; steps[4] = GRC | ROUT | ZIN; steps[5] = ZLOWOUT | GRA | RIN; end
      2: begin steps[3] = GRA | ROUT | YIN; steps[4] = GRB | ROUT | ZIN;
               steps[5] = ZLOWOUT | LOIN; steps[6] = ZHIGHOUT | HIIN; end
      3: begin steps[3] = GRB | ROUT | ZIN; steps[4] = ZLOWOUT | GRA | RIN; end
      4: steps[3] = HIOUT | GRA | RIN;
      5: steps[3] = LOOUT | GRA | RIN;
      0: steps[3] = ILL;
      default: steps[3] = 22'd0;
    endcase
    return steps[k];
  endfunction

  function automatic logic [3:0] step_alu(logic [4:0] op, int k);
    return (k >= 3 && (step_mask(op, k) & ZIN) != 22'd0) ? alu_of(op) : 4'd0;
  endfunction

  int          k = 0;
  bit          halted = 1'b0, valid = 1'b0;
  logic [4:0]  cur_op = 5'd0;

  // compare on the falling edge, advance the model on the rising edge
  initial begin
    logic [21:0] em;
    logic [3:0]  ea;
    logic        er;
    forever begin
      @(negedge Clock);
      if (valid) begin
        if (Clear)       begin em = 22'd0; ea = 4'd0; er = 1'b1; end
        else if (halted) begin em = 22'd0; ea = 4'd0; er = 1'b0; end
        else begin
          em = step_mask(cur_op, k) | ((k == 1 && bus.mem_ready) ? MDRIN : 22'd0);
          ea = step_alu(cur_op, k);
          er = 1'b1;
        end
        chk($sformatf("model k=%0d op=%b", k, cur_op), {5'd0, dut_mask, bus.alu_op, bus.Run},
            {5'd0, em, ea, er});
      end
      @(posedge Clock);
      if (Clear) begin k = 0; halted = 1'b0; valid = 1'b1; end
      else if (valid && !halted) begin
        if (k == 1 && !bus.mem_ready) k = 1;
        else if (k == 2) begin cur_op = bus.IR[31:27]; k = 3; end
        else if (k == 3 && kind(cur_op) == 7) halted = 1'b1;
        else begin
          k = k + 1;
          if (k >= 3 && k == instr_len(cur_op)) k = 0;
        end
      end
    end
  end

  // ---- directed helpers ----
  logic [21:0] rec_mask [16];
  logic [3:0]  rec_alu  [16];
  logic        rec_run  [16];

  task automatic do_clear();
    Clear = 1'b1;
    @(posedge Clock); #1;
    Clear = 1'b0;
  endtask

  task automatic capture(int n, logic [15:0] stall, logic [15:0] clr);
    for (int c = 0; c < n; c++) begin
      bus.mem_ready = ~stall[c];
      Clear = clr[c];
      @(negedge Clock);
      rec_mask[c] = dut_mask;
      rec_alu[c]  = bus.alu_op;
      rec_run[c]  = bus.Run;
      @(posedge Clock); #1;
    end
    Clear = 1'b0;
    bus.mem_ready = 1'b1;
  endtask

  initial begin
    logic [4:0] ops [17] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                             5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001,
                             5'b10010, 5'b11000, 5'b11001, 5'b11010, 5'b11011};
    int cnt;
    logic [3:0] mdr_vec;
    logic [4:0] op;

    bus.IR = 32'h0; bus.mem_ready = 1'b1; Clear = 1'b1;
    @(negedge Clock);
    chk("clear_strobes", dut_mask, 22'd0);
    chk("clear_alu", bus.alu_op, 4'd0);
    chk("clear_run", bus.Run, 1'b1);
    @(posedge Clock); #1;

    // model pins
    chk("model_len_mul", instr_len(5'b01111), 7);
    chk("model_and_T5", step_mask(5'b00101, 5), ZLOWOUT | GRA | RIN);

    // and R1,R2,R3
    bus.IR = 32'h28918000;
    do_clear();
    capture(7, 16'h0, 16'h0);
    chk("and_T0", rec_mask[0], M_T0);
    chk("and_T0_alu", rec_alu[0], 4'd0);
    chk("and_T0_run", rec_run[0], 1'b1);
    chk("and_T1", rec_mask[1], ZLOWOUT | PCIN | READ | MDRIN);
    chk("and_T4", rec_mask[4], GRC | ROUT | ZIN);
    chk("and_T4_alu", rec_alu[4], 4'd3);
    chk("and_T5", rec_mask[5], ZLOWOUT | GRA | RIN);
    chk("and_back_T0", rec_mask[6], M_T0);

    // memory stall in T1 for three cycles
    do_clear();
    capture(7, 16'b0000_0000_0000_1110, 16'h0);
    cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      if ((rec_mask[c] & READ) != 22'd0) cnt++;
      mdr_vec[c-1] = (rec_mask[c] & MDRIN) != 22'd0;
    end
    chk("stall_read_cycles", cnt, 4);
    chk("stall_mdrin", mdr_vec, 4'b1000);
    chk("stall_T2", rec_mask[5], MDROUT | IRIN);

    // mul R3,R4
    bus.IR = 32'h79A00000;
    do_clear();
    capture(8, 16'h0, 16'h0);
    chk("mul_T3", rec_mask[3], GRA | ROUT | YIN);
    chk("mul_T4_alu", rec_alu[4], 4'd10);
    chk("mul_T5", rec_mask[5], ZLOWOUT | LOIN);
    chk("mul_T6", rec_mask[6], ZHIGHOUT | HIIN);
    chk("mul_back_T0", rec_mask[7], M_T0);

    // halt
    bus.IR = 32'hD8000000;
    do_clear();
    capture(15, 16'h0, 16'h0);
    chk("halt_T3", rec_mask[3], 22'd0);
    cnt = 0;
    for (int c = 4; c < 15; c++) if (rec_mask[c] != 22'd0 || rec_run[c] != 1'b0) cnt++;
    chk("halt_idle", cnt, 0);
    do_clear();
    capture(1, 16'h0, 16'h0);
    chk("halt_clear_T0", rec_mask[0], M_T0);
    chk("halt_clear_run", rec_run[0], 1'b1);

    // Clear during T4 of add
    bus.IR = 32'h18000000;
    do_clear();
    capture(8, 16'h0, 16'b0000_0000_0001_0000);
    chk("abort_T4", rec_mask[4], 22'd0);
    chk("abort_next_T0", rec_mask[5], M_T0);
    cnt = 0;
    for (int c = 0; c < 8; c++) if ((rec_mask[c] & RIN) != 22'd0) cnt++;
    chk("abort_no_rin", cnt, 0);

    // unsupported opcode
    bus.IR = 32'h00000000;
    do_clear();
    capture(5, 16'h0, 16'h0);
    chk("ill_T3", rec_mask[3], ILL);
    cnt = 0;
    for (int c = 0; c < 5; c++) if ((rec_mask[c] & ILL) != 22'd0) cnt++;
    chk("ill_single_pulse", cnt, 1);
    chk("ill_next_T0", rec_mask[4], M_T0);

    // randomized run against the model
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      Clear = ($urandom_range(0, 59) == 0) || (halted && $urandom_range(0, 5) == 0);
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) op = 5'($urandom_range(0, 31));
      else op = ops[$urandom_range(0, 16)];
      bus.IR = {op, 27'($urandom)};
      @(posedge Clock); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
